// File: rtl/aes_const.sv
// AES constants shared by the core and its sequencers:
// block and key geometry, plus the core function codes.
package aes_const;
    localparam int Nb = 4;
    localparam int Nk = 4;
    localparam int AES_BLK_W = 32 * Nb;
    localparam int AES_KEY_W = 32 * Nk;
    localparam logic [1:0] AES_FUNC_KEY = 2'd1;
    localparam logic [1:0] AES_FUNC_ENC = 2'd2;
    localparam logic [1:0] AES_FUNC_DEC = 2'd3;
endpackage

// File: rtl/aes_wire.sv
// Bundles exchanged with the AES core, plus the CTR sequencer state type.
package aes_wire;
    import aes_const::*;

    typedef struct packed {
        logic [AES_KEY_W-1:0] key;
        logic [AES_BLK_W-1:0] data;
        logic [1:0]           func;
        logic                 enable;
    } aes_in_type;

    typedef struct packed {
        logic [AES_BLK_W-1:0] result;
        logic                 ready;
    } aes_out_type;

    typedef enum logic [2:0] {
        IDLE,
        KEY,
        WAIT_IN,
        ENC,
        OUT
    } aes_ctr_state_type;
endpackage

// File: rtl/aes_ctr_inc.sv
// Masked counter-block incrementer: the low CTR_WIDTH bits wrap,
// the upper bits pass through untouched.
module aes_ctr_inc
    import aes_const::*;
#(
    parameter int CTR_WIDTH = 32
) (
    input  logic [AES_BLK_W-1:0] ctr,
    output logic [AES_BLK_W-1:0] ctr_next
);
    localparam logic [AES_BLK_W-1:0] MASK =
        {AES_BLK_W{1'b1}} >> (AES_BLK_W - CTR_WIDTH);
    localparam logic [AES_BLK_W-1:0] ONE =
        {{(AES_BLK_W-1){1'b0}}, 1'b1};

    logic [AES_BLK_W-1:0] sum;

    assign sum      = ctr + ONE;
    assign ctr_next = (ctr & ~MASK) | (sum & MASK);
endmodule

// File: rtl/aes_ctr_ctrl.sv
// CTR-mode sequencer in front of a shared AES core (key load, encrypt, XOR).
// Define AES_CTR_BLOCK_COUNT_EN to add the blk_count output.
module aes_ctr_ctrl
    import aes_const::*;
    import aes_wire::*;
#(
    parameter int CTR_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [AES_KEY_W-1:0] cfg_key,
    input  logic [AES_BLK_W-1:0] cfg_iv,
    input  logic                 cfg_start,
    input  logic                 cfg_stop,
    output logic                 busy,
    input  logic                 in_valid,
    input  logic [AES_BLK_W-1:0] in_data,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic [AES_BLK_W-1:0] out_data,
    input  logic                 out_ready,
    output aes_in_type           aes_in,
    input  aes_out_type          aes_out
`ifdef AES_CTR_BLOCK_COUNT_EN
    ,
    output logic [31:0]          blk_count
`endif
);
    aes_ctr_state_type    state;
    aes_ctr_state_type    state_d;
    logic                 stop_pending;
    logic [AES_BLK_W-1:0] ctr;
    logic [AES_BLK_W-1:0] ctr_next;
    logic [AES_BLK_W-1:0] held;
    logic                 key_ld;
    logic                 enc_go;
    logic                 enc_done;
    logic                 out_hs;
    logic                 stop_set;
    logic                 stop_clr;

    aes_ctr_inc #(
        .CTR_WIDTH (CTR_WIDTH)
    ) u_inc (
        .ctr      (ctr),
        .ctr_next (ctr_next)
    );

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d  = state;
        in_ready = 1'b0;
        key_ld   = 1'b0;
        enc_go   = 1'b0;
        enc_done = 1'b0;
        out_hs   = 1'b0;
        stop_set = 1'b0;
        stop_clr = 1'b0;
        unique case (state)
            IDLE: begin
                if (cfg_start) begin
                    key_ld  = 1'b1;
                    state_d = KEY;
                end
            end
            KEY: begin
                stop_set = cfg_stop;
                state_d  = WAIT_IN;
            end
            WAIT_IN: begin
                if (cfg_stop || stop_pending) begin
                    stop_clr = 1'b1;
                    state_d  = IDLE;
                end else begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        enc_go  = 1'b1;
                        state_d = ENC;
                    end
                end
            end
            ENC: begin
                stop_set = cfg_stop;
                if (aes_out.ready) begin
                    enc_done = 1'b1;
                    state_d  = OUT;
                end
            end
            OUT: begin
                stop_set = cfg_stop;
                if (out_ready) begin
                    out_hs = 1'b1;
                    if (stop_pending || cfg_stop) begin
                        stop_clr = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        state_d = WAIT_IN;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // enable is a one-cycle strobe; func/data stay put while the core works
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aes_in       <= '0;
            ctr          <= '0;
            held         <= '0;
            out_data     <= '0;
            out_valid    <= 1'b0;
            stop_pending <= 1'b0;
        end else begin
            aes_in.enable <= key_ld | enc_go;
            aes_in.key    <= key_ld ? cfg_key : '0;
            if (key_ld) begin
                aes_in.func <= AES_FUNC_KEY;
                ctr         <= cfg_iv;
            end
            if (enc_go) begin
                aes_in.func <= AES_FUNC_ENC;
                aes_in.data <= ctr;
                held        <= in_data;
            end
            if (enc_done) begin
                out_data  <= aes_out.result ^ held;
                out_valid <= 1'b1;
                ctr       <= ctr_next;
            end
            if (out_hs) begin
                out_valid <= 1'b0;
            end
            if (stop_clr || key_ld) begin
                stop_pending <= 1'b0;
            end else if (stop_set) begin
                stop_pending <= 1'b1;
            end
        end
    end

`ifdef AES_CTR_BLOCK_COUNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blk_count <= '0;
        end else if (key_ld) begin
            blk_count <= '0;
        end else if (out_hs) begin
            blk_count <= blk_count + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_aes_ctr_ctrl.sv
// Bench for aes_ctr_ctrl: behavioural AES-128 core, CTR reference model.
// Define AES_CTR_BLOCK_COUNT_EN to also check blk_count.
module tb_aes_ctr_ctrl;
    import aes_const::*;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] cfg_key, cfg_iv;
    logic         cfg_start, cfg_stop;
    logic         busy;
    logic         in_valid, in_ready;
    logic [127:0] in_data;
    logic         out_valid, out_ready;
    logic [127:0] out_data;
    aes_wire::aes_in_type  aes_in;
    aes_wire::aes_out_type aes_out;
`ifdef AES_CTR_BLOCK_COUNT_EN
    logic [31:0]  blk_count;
`endif

    aes_ctr_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_key   (cfg_key),
        .cfg_iv    (cfg_iv),
        .cfg_start (cfg_start),
        .cfg_stop  (cfg_stop),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .aes_in    (aes_in),
        .aes_out   (aes_out)
`ifdef AES_CTR_BLOCK_COUNT_EN
        ,
        .blk_count (blk_count)
`endif
    );

    logic [127:0] inc_a, inc8_y, inc128_y;
    aes_ctr_inc #(.CTR_WIDTH(8))   u_inc8   (.ctr(inc_a), .ctr_next(inc8_y));
    aes_ctr_inc #(.CTR_WIDTH(128)) u_inc128 (.ctr(inc_a), .ctr_next(inc128_y));

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic chkb(input string nm, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, want %b", nm, act, exp);
        end
    endtask

    // ---------------- behavioural AES-128 ----------------
    logic [7:0] sbox [256];

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rl(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b};
        t = t >> (8 - n);
        return t[7:0];
    endfunction

    task automatic build_sbox();
        logic [7:0] x, inv;
        for (int i = 0; i < 256; i++) begin
            x = 8'(i);
            inv = 8'h00;
            if (x != 8'h00) begin
                inv = 8'h01;
                for (int k = 0; k < 254; k++) inv = gm(inv, x);
            end
            sbox[i] = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes128_enc(input logic [127:0] k, input logic [127:0] pt);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   rc, a0, a1, a2, a3;
        logic [31:0]  tmp;
        logic [127:0] ct;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]], sbox[tmp[31:24]]}
                      ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8];
        for (int r = 0; r <= 10; r++) begin
            if (r > 0) begin
                for (int i = 0; i < 16; i++) s[i] = sbox[s[i]];
                for (int c = 0; c < 4; c++)
                    for (int q = 0; q < 4; q++) t[q+4*c] = s[q+4*((c+q)%4)];
                s = t;
                if (r < 10) begin
                    for (int c = 0; c < 4; c++) begin
                        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                        s[4*c]   = gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3;
                        s[4*c+1] = a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3;
                        s[4*c+2] = a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03);
                        s[4*c+3] = gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02);
                    end
                end
            end
            for (int c = 0; c < 4; c++)
                for (int q = 0; q < 4; q++) s[4*c+q] ^= w[4*r+c][31-8*q -: 8];
        end
        for (int i = 0; i < 16; i++) ct[127-8*i -: 8] = s[i];
        return ct;
    endfunction

    // ---------------- core model ----------------
    logic [127:0] core_key, core_pt;
    logic         core_busy;
    int           core_cnt;
    int           core_lat = 2;
    logic         prev_en;
    logic         en_twice = 1'b0;
    int           n_en = 0;
    logic [127:0] ctr_log [$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            aes_out   <= '0;
            core_key  <= '0;
            core_pt   <= '0;
            core_busy <= 1'b0;
            core_cnt  <= 0;
            prev_en   <= 1'b0;
        end else begin
            aes_out.ready <= 1'b0;
            prev_en       <= aes_in.enable;
            if (prev_en && aes_in.enable) en_twice <= 1'b1;
            if (core_busy) begin
                if (core_cnt <= 1) begin
                    aes_out.ready  <= 1'b1;
                    aes_out.result <= aes128_enc(core_key, core_pt);
                    core_busy      <= 1'b0;
                end else begin
                    core_cnt <= core_cnt - 1;
                end
            end
            if (aes_in.enable) begin
                n_en <= n_en + 1;
                if (aes_in.func == AES_FUNC_KEY) begin
                    core_key <= aes_in.key;
                end else if (aes_in.func == AES_FUNC_ENC) begin
                    core_busy <= 1'b1;
                    core_cnt  <= core_lat;
                    core_pt   <= aes_in.data;
                    ctr_log.push_back(aes_in.data);
                end
            end
        end
    end

    // ---------------- CTR reference model ----------------
    logic [127:0] m_key, m_iv;
    logic [31:0]  m_idx;

    function automatic logic [127:0] m_ctr();
        return {m_iv[127:32], m_iv[31:0] + m_idx};
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_sess(input logic [127:0] k, input logic [127:0] iv);
        cfg_key   = k;
        cfg_iv    = iv;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        tick();
        m_key = k;
        m_iv  = iv;
        m_idx = '0;
    endtask

    task automatic stop_sess();
        cfg_stop = 1'b1;
        tick();
        cfg_stop = 1'b0;
    endtask

    task automatic send_block(input logic [127:0] d, output bit ok);
        in_data  = d;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic get_out(input int stall, output logic [127:0] d, output bit ok);
        out_ready = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (stall) @(negedge clk);
        d = out_data;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic xfer(input string nm, input logic [127:0] din, input int stall);
        logic [127:0] d, ec;
        bit ok;
        ec = m_ctr();
        send_block(din, ok);
        if (!ok) chkb({nm, " accept timeout"}, ok, 1'b1);
        get_out(stall, d, ok);
        if (!ok) chkb({nm, " out_valid timeout"}, ok, 1'b1);
        chk({nm, " data"}, d, din ^ aes128_enc(m_key, ec));
        chk({nm, " ctr"}, ctr_log[$], ec);
        m_idx++;
    endtask

    typedef struct {
        bit           new_sess;
        logic [127:0] key;
        logic [127:0] iv;
        logic [127:0] din;
        bit           use_model;
        logic [127:0] exp_out;
        logic [127:0] exp_ctr;
    } vec_t;

    typedef struct {
        logic [127:0] a;
        logic [127:0] e8;
        logic [127:0] e128;
    } inc_vec_t;

    localparam logic [127:0] K1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] IV1 = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
    localparam logic [127:0] IVW = 128'h000102030405060708090a0bffffffff;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t         tbl [4];
        inc_vec_t     itbl [3];
        logic [127:0] d, v, e;
        bit           ok, stable;
        int           en0;

        tbl[0] = '{new_sess: 0, key: K1, iv: IV1,
                   din: 128'h6bc1bee22e409f96e93d7e117393172a, use_model: 0,
                   exp_out: 128'h874d6191b620e3261bef6864990db6ce, exp_ctr: IV1};
        tbl[1] = '{new_sess: 0, key: K1, iv: IV1,
                   din: 128'hae2d8a571e03ac9c9eb76fac45af8e51, use_model: 0,
                   exp_out: 128'h9806f66b7970fdff8617187bb9fffdff,
                   exp_ctr: 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff00};
        tbl[2] = '{new_sess: 1, key: K1, iv: IVW,
                   din: 128'h00112233445566778899aabbccddeeff, use_model: 1,
                   exp_out: '0, exp_ctr: IVW};
        tbl[3] = '{new_sess: 0, key: K1, iv: IVW,
                   din: 128'hdeadbeef0123456789abcdeffedcba98, use_model: 1,
                   exp_out: '0, exp_ctr: 128'h000102030405060708090a0b00000000};
        itbl[0] = '{a: 128'h0123456789abcdef00112233445566ff,
                    e8: 128'h0123456789abcdef0011223344556600,
                    e128: 128'h0123456789abcdef0011223344556700};
        itbl[1] = '{a: {128{1'b1}}, e8: {{120{1'b1}}, 8'h00}, e128: '0};
        itbl[2] = '{a: '0, e8: 128'h1, e128: 128'h1};

        build_sbox();
        rst = 1'b1;
        cfg_key = '0; cfg_iv = '0; cfg_start = 1'b0; cfg_stop = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0; inc_a = '0;
        repeat (3) tick();
        chkb("reset busy", busy, 1'b0);
        chkb("reset in_ready", in_ready, 1'b0);
        chkb("reset out_valid", out_valid, 1'b0);
        chk("reset out_data", out_data, '0);
        chkb("reset aes_in zero", aes_in == '0, 1'b1);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 3; i++) begin
            inc_a = itbl[i].a;
            #1;
            chk($sformatf("inc8[%0d]", i), inc8_y, itbl[i].e8);
            chk($sformatf("inc128[%0d]", i), inc128_y, itbl[i].e128);
        end

        // key load timing
        cfg_key = K1; cfg_iv = IV1; cfg_start = 1'b1;
        chkb("start busy before edge", busy, 1'b0);
        tick();
        cfg_start = 1'b0;
        chkb("key busy", busy, 1'b1);
        chkb("key enable", aes_in.enable, 1'b1);
        chk("key func", 128'(aes_in.func), 128'(AES_FUNC_KEY));
        chk("key bus", aes_in.key, K1);
        chkb("key in_ready", in_ready, 1'b0);
        tick();
        chkb("post-key enable", aes_in.enable, 1'b0);
        chk("post-key key bus", aes_in.key, '0);
        chkb("post-key in_ready", in_ready, 1'b1);

        for (int i = 0; i < 4; i++) begin
            if (tbl[i].new_sess) begin
                stop_sess();
                chkb($sformatf("vec%0d stop idle", i), busy, 1'b0);
                start_sess(tbl[i].key, tbl[i].iv);
            end
            send_block(tbl[i].din, ok);
            if (!ok) chkb($sformatf("vec%0d accept timeout", i), ok, 1'b1);
            get_out(0, d, ok);
            if (!ok) chkb($sformatf("vec%0d out timeout", i), ok, 1'b1);
            e = tbl[i].use_model ? tbl[i].din ^ aes128_enc(tbl[i].key, tbl[i].exp_ctr)
                                 : tbl[i].exp_out;
            chk($sformatf("vec%0d out", i), d, e);
            chk($sformatf("vec%0d ctr", i), ctr_log[$], tbl[i].exp_ctr);
        end
        m_key = K1; m_iv = IVW; m_idx = 32'd2;

        // backpressure
        d = rnd128();
        e = d ^ aes128_enc(m_key, m_ctr());
        send_block(d, ok);
        out_ready = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chkb("bp out_valid timeout", ok, 1'b1);
        v = out_data;
        en0 = n_en;
        stable = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (!out_valid || out_data !== v || in_ready) stable = 1'b0;
        end
        chkb("bp stable", stable, 1'b1);
        chk("bp no enable", 128'(n_en), 128'(en0));
        chk("bp data", v, e);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chkb("bp valid drop", out_valid, 1'b0);
        chkb("bp in_ready back", in_ready, 1'b1);
        m_idx++;

        // stop during ENC: block still delivered
        core_lat = 6;
        d = rnd128();
        e = d ^ aes128_enc(m_key, m_ctr());
        send_block(d, ok);
        tick();
        cfg_stop = 1'b1;
        tick();
        cfg_stop = 1'b0;
        chkb("stop busy in ENC", busy, 1'b1);
        get_out(0, v, ok);
        if (!ok) chkb("stop out timeout", ok, 1'b1);
        chk("stop data", v, e);
        chkb("stop idle", busy, 1'b0);
        chkb("stop in_ready", in_ready, 1'b0);

        // start while busy is ignored
        core_lat = 3;
        start_sess(rnd128(), rnd128());
        xfer("sess2 b0", rnd128(), 1);
        en0 = n_en;
        cfg_key = rnd128(); cfg_iv = rnd128(); cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        chk("busy start no key", 128'(n_en), 128'(en0));
        xfer("sess2 b1", rnd128(), 0);

`ifdef AES_CTR_BLOCK_COUNT_EN
        stop_sess();
        start_sess(rnd128(), rnd128());
        chk("blk_count clear", 128'(blk_count), 128'd0);
        xfer("cnt b0", rnd128(), 0);
        xfer("cnt b1", rnd128(), 2);
        chk("blk_count two", 128'(blk_count), 128'd2);
`endif

        for (int s = 0; s < 3; s++) begin
            stop_sess();
            v = rnd128();
            v[31:0] = 32'hffffffff - 32'($urandom_range(0, 5));
            start_sess(rnd128(), v);
            for (int b = 0; b < 8; b++) begin
                core_lat = $urandom_range(1, 4);
                xfer($sformatf("rnd s%0d b%0d", s, b), rnd128(),
                     int'($urandom_range(0, 3)));
            end
        end

        // reset mid-ENC
        core_lat = 6;
        send_block(rnd128(), ok);
        tick();
        #2;
        rst = 1'b1;
        #1;
        chkb("midrst busy", busy, 1'b0);
        chkb("midrst in_ready", in_ready, 1'b0);
        chkb("midrst out_valid", out_valid, 1'b0);
        chk("midrst out_data", out_data, '0);
        chkb("midrst aes_in zero", aes_in == '0, 1'b1);
        tick();
        rst = 1'b0;
        tick();
        core_lat = 2;
        start_sess(K1, IV1);
        xfer("after rst", 128'h6bc1bee22e409f96e93d7e117393172a, 0);

        chkb("enable never back-to-back", en_twice, 1'b0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
